audio_clip_player: RTL and testbench
====================================

// Module: audio_clip_player
// PURPOSE
//  Multi-clip, parametrised playback engine for game sound effects (win, moo, detect, cheer).
//  Plays one clip stored in a single synchronous sample ROM, in one-shot or loop mode, at a fixed sample rate.
//  Supports stop, optional pre-emption, a done pulse and a drop counter; replaces the ad-hoc address counter in the datapath.
//  Sits between the game FSM (requests) and the sample ROM / Audio_Controller (write_audio_out path).
// PARAMETERS
//  ADDR_W     18       ROM address width
//  SAMPLE_W   6        ROM sample width
//  OUT_W      32       audio word width to Audio_Controller
//  NUM_CLIPS  4        number of clips; CLIP_W = $clog2(NUM_CLIPS)
//  CLIP_START {..}     packed NUM_CLIPS*ADDR_W start addresses; clip 0 in LSBs
//  CLIP_END   {..}     packed NUM_CLIPS*ADDR_W inclusive end addresses; END >= START per clip
//  DIV_COUNT  1200     CLOCK_50 cycles per sample; minimum 3
//  PREEMPT    1        1: request while busy restarts playback; 0: request while busy is refused
//  STEREO     0        1: right channel copies left; 0: right channel = 0
// PORTS
//  CLOCK_50                  in   1         system clock
//  reset                     in   1         synchronous, active-high
//  play_req                  in   1         request pulse/level; sampled only when play_ack can be high
//  play_clip                 in   CLIP_W    clip index; values >= NUM_CLIPS are refused
//  play_loop                 in   1         1: loop clip until stop; 0: one-shot
//  stop                      in   1         abort playback
//  play_ack                  out  1         1-cycle pulse: request accepted
//  busy                      out  1         high while playing
//  done                      out  1         1-cycle pulse: one-shot clip reached its end naturally
//  rom_addr                  out  ADDR_W    registered ROM address
//  rom_q                     in   SAMPLE_W  ROM data; valid 1 cycle after rom_addr
//  audio_out_allowed         in   1         from Audio_Controller
//  write_audio_out           out  1         1-cycle write strobe per sample tick
//  left_channel_audio_out    out  OUT_W     {sample, zeros}
//  right_channel_audio_out   out  OUT_W     per STEREO
//  drop_count                out  8         saturating count of ticks with audio_out_allowed low
// BEHAVIOUR
//  Reset (sync, high): state IDLE, all outputs 0 (rom_addr = 0, drop_count = 0, channels = 0). Reset mid-play aborts with no done pulse.
//  States: IDLE, PLAY.
//   IDLE -> PLAY when play_req && play_clip < NUM_CLIPS.
//   PLAY -> IDLE on stop, or at the end of a one-shot clip.
//  Accept at cycle T: play_ack = 1 at T+1, busy = 1 from T+1, rom_addr = START at T+1; divider cleared at T.
//   Clip index and loop mode are latched at accept.
//  Divider: counts 0..DIV_COUNT-1; tick when it reaches DIV_COUNT-1, then wraps to 0. First tick is at T+DIV_COUNT.
//  On each tick (PLAY):
//   - If audio_out_allowed: write_audio_out = 1 that cycle and the channels carry the current sample.
//   - Else: write suppressed and drop_count increments (saturates at 255, cleared only by reset).
//   - Address advances regardless (real-time pacing).
//   - Sample register captures rom_q 2 cycles after each rom_addr change and is stable before the next tick.
//  End of clip (tick with rom_addr == END):
//   - Loop mode: rom_addr <= START.
//   - One-shot: done = 1 the next cycle, busy = 0, state IDLE, channels return to 0.
//  Single-sample clip (START == END): exactly one write, then done.
//  Priority in one cycle: reset > stop > accepted request > end-of-clip.
//   - stop: busy = 0 the next cycle, no done pulse, no write even if that cycle is a tick; stop in IDLE has no effect.
//   - Request while busy, PREEMPT = 1: restart as from IDLE. No done pulse for the aborted clip unless its natural one-shot end coincides, in which case done and play_ack both pulse.
//   - Request while busy, PREEMPT = 0: ignored, no play_ack.
//  Invalid clip index: never acknowledged; state is unchanged.
//  Sample mapping: left = {sample, (OUT_W-SAMPLE_W)'b0}, unsigned as stored.
//  Address arithmetic: ADDR_W wide, no wrap beyond END.
// STRUCTURE
//  Shared package (audio_pkg): clip-index localparams (CLIP_WIN = 0, CLIP_MOO = 1, CLIP_DETECT = 2, CLIP_CHEER = 3) and the default start/end table (0/16395, 16396/66982, 66983/83254, 83255/137138).
//  One sub-module: sample_rate_divider (counter, sync clear input, tick output, DIV_COUNT parameter).
//  Everything else stays in the top: FSM, address counter, sample register, output formatting.
// TESTING (DIV_COUNT = 4, NUM_CLIPS = 4, table 0-3, 4-9, 10-10, 11-20; ROM model returns addr[5:0]; allowed = 1 unless stated)
//  1 Clip 0 one-shot: writes at T+4, T+8, T+12, T+16 with samples 0,1,2,3; done at T+17; busy low at T+17.
//  2 Clip 2 one-shot (single sample): one write with sample 10 at T+4, then done; clip index 5 -> no play_ack, stays IDLE.
//  3 Clip 1 loop: sample sequence 4..9,4..9,...; stop at the 9th tick -> no write that cycle, busy = 0 next cycle, no done.
//  4 PREEMPT = 1: clip 3 playing, request clip 0 -> next writes 0,1,... with no done; PREEMPT = 0: request ignored, clip 3 continues.
//  5 Allowed low for 3 ticks of clip 1 -> drop_count = 3, addresses still advance (next write carries sample 7).
//  6 Reset asserted mid-clip -> next cycle all outputs 0; request with stop in the same cycle in IDLE -> no play_ack.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared clip identifiers and the default ROM layout for the game's sound effects.
package audio_pkg;

  localparam int CLIP_WIN    = 0;
  localparam int CLIP_MOO    = 1;
  localparam int CLIP_DETECT = 2;
  localparam int CLIP_CHEER  = 3;

  localparam int DEFAULT_NUM_CLIPS = 4;
  localparam int DEFAULT_ADDR_W    = 18;

  // Clip 0 sits in the least significant field of each packed table.
  localparam logic [DEFAULT_NUM_CLIPS*DEFAULT_ADDR_W-1:0] DEFAULT_CLIP_START =
    {18'd83255, 18'd66983, 18'd16396, 18'd0};
  localparam logic [DEFAULT_NUM_CLIPS*DEFAULT_ADDR_W-1:0] DEFAULT_CLIP_END =
    {18'd137138, 18'd83254, 18'd66982, 18'd16395};

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running 0..DIV_COUNT-1 counter; tick_o is high on the last count.
module sample_rate_divider #(
  parameter int DIV_COUNT = 1200
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/audio_clip_player.sv
// Clip playback engine: walks a clip's ROM address range at the sample rate and
// hands each sample to the Audio_Controller, with loop, stop and pre-emption.
module audio_clip_player
  import audio_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int SAMPLE_W  = 6,
  parameter int OUT_W     = 32,
  parameter int NUM_CLIPS = 4,
  localparam int CLIP_W   = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START = DEFAULT_CLIP_START,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END   = DEFAULT_CLIP_END,
  parameter int DIV_COUNT = 1200,
  parameter bit PREEMPT   = 1'b1,
  parameter bit STEREO    = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                play_req,
  input  logic [CLIP_W-1:0]   play_clip,
  input  logic                play_loop,
  input  logic                stop,
  output logic                play_ack,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_channel_audio_out,
  output logic [OUT_W-1:0]    right_channel_audio_out,
  output logic [7:0]          drop_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;
  localparam logic [CLIP_W:0] NUM_CLIPS_L = (CLIP_W + 1)'(NUM_CLIPS);

  logic [ADDR_W-1:0] start_tbl [NUM_CLIPS];
  logic [ADDR_W-1:0] end_tbl   [NUM_CLIPS];

  for (genvar i = 0; i < NUM_CLIPS; i++) begin : g_tbl
    assign start_tbl[i] = CLIP_START[i*ADDR_W +: ADDR_W];
    assign end_tbl[i]   = CLIP_END[i*ADDR_W +: ADDR_W];
  end

  logic [0:0]          state_q, state_d;
  logic [CLIP_W-1:0]   clip_q, clip_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic [7:0]          drop_q, drop_d;

  logic tick, playing, tick_play, accept, at_end;

  assign playing   = (state_q == ST_PLAY);
  assign tick_play = playing && tick;
  assign at_end    = (addr_q == end_tbl[clip_q]);
  assign accept    = play_req && !stop && ({1'b0, play_clip} < NUM_CLIPS_L)
                     && (!playing || PREEMPT);

  sample_rate_divider #(
    .DIV_COUNT (DIV_COUNT)
  ) u_div (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .clear_i (!playing || accept),
    .tick_o  (tick)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    clip_d  = clip_q;
    loop_d  = loop_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    drop_d  = drop_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      if (tick_play) begin
        if (!audio_out_allowed && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (!at_end) begin
          addr_d = addr_q + ADDR_W'(1);
        end else if (loop_q) begin
          addr_d = start_tbl[clip_q];
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      // A new request overrides the end-of-clip transition but keeps its done pulse.
      if (accept) begin
        state_d = ST_PLAY;
        clip_d  = play_clip;
        loop_d  = play_loop;
        addr_d  = start_tbl[play_clip];
        ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      clip_q   <= '0;
      loop_q   <= 1'b0;
      addr_q   <= '0;
      sample_q <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      clip_q   <= clip_d;
      loop_q   <= loop_d;
      addr_q   <= addr_d;
      sample_q <= rom_q;
      ack_q    <= ack_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign play_ack   = ack_q;
  assign busy       = playing;
  assign done       = done_q;
  assign rom_addr   = addr_q;
  assign drop_count = drop_q;

  assign write_audio_out         = tick_play && audio_out_allowed && !stop;
  assign left_channel_audio_out  = playing ? {sample_q, {(OUT_W-SAMPLE_W){1'b0}}} : '0;
  assign right_channel_audio_out = STEREO ? left_channel_audio_out : '0;

endmodule

// File: tb/tb_audio_clip_player.sv
// Directed bench for audio_clip_player: two instances (pre-emptive mono, non-pre-emptive
// stereo with a fifth clip) checked through per-instance event scoreboards.
module tb_audio_clip_player;

  typedef enum {EV_ACK, EV_DONE, EV_WR} kind_e;
  typedef struct {
    kind_e       kind;
    int          cyc;
    logic [31:0] left;
    logic [31:0] right;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q_a[$];
  ev_t  q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_req = 0, a_loop = 0, a_stop = 0, a_allowed = 1;
  logic [1:0]  a_clip = 0;
  logic        a_ack, a_busy, a_done, a_wr;
  logic [17:0] a_addr;
  logic [5:0]  a_rom_q;
  logic [31:0] a_left, a_right;
  logic [7:0]  a_drop;

  logic        b_req = 0, b_loop = 0, b_stop = 0, b_allowed = 1;
  logic [2:0]  b_clip = 0;
  logic        b_ack, b_busy, b_done, b_wr;
  logic [17:0] b_addr;
  logic [5:0]  b_rom_q;
  logic [31:0] b_left, b_right;
  logic [7:0]  b_drop;

  always @(posedge clk) a_rom_q <= a_addr[5:0];
  always @(posedge clk) b_rom_q <= b_addr[5:0];

  audio_clip_player #(
    .NUM_CLIPS (4),
    .CLIP_START({18'd11, 18'd10, 18'd4, 18'd0}),
    .CLIP_END  ({18'd20, 18'd10, 18'd9, 18'd3}),
    .DIV_COUNT (4),
    .PREEMPT   (1'b1),
    .STEREO    (1'b0)
  ) dut_a (
    .CLOCK_50(clk), .reset(rst), .play_req(a_req), .play_clip(a_clip), .play_loop(a_loop),
    .stop(a_stop), .play_ack(a_ack), .busy(a_busy), .done(a_done), .rom_addr(a_addr),
    .rom_q(a_rom_q), .audio_out_allowed(a_allowed), .write_audio_out(a_wr),
    .left_channel_audio_out(a_left), .right_channel_audio_out(a_right), .drop_count(a_drop)
  );

  audio_clip_player #(
    .NUM_CLIPS (5),
    .CLIP_START({18'd21, 18'd11, 18'd10, 18'd4, 18'd0}),
    .CLIP_END  ({18'd22, 18'd20, 18'd10, 18'd9, 18'd3}),
    .DIV_COUNT (4),
    .PREEMPT   (1'b0),
    .STEREO    (1'b1)
  ) dut_b (
    .CLOCK_50(clk), .reset(rst), .play_req(b_req), .play_clip(b_clip), .play_loop(b_loop),
    .stop(b_stop), .play_ack(b_ack), .busy(b_busy), .done(b_done), .rom_addr(b_addr),
    .rom_q(b_rom_q), .audio_out_allowed(b_allowed), .write_audio_out(b_wr),
    .left_channel_audio_out(b_left), .right_channel_audio_out(b_right), .drop_count(b_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input kind_e kind, input int at, input int sample);
    ev_t e;
    logic [5:0] s;
    s = sample[5:0];
    e.kind  = kind;
    e.cyc   = at;
    e.left  = (kind == EV_WR) ? {s, 26'd0} : 32'd0;
    e.right = (kind == EV_WR && id == 1) ? {s, 26'd0} : 32'd0;
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  task automatic sb_pop(input int id, input kind_e kind, input logic [31:0] l, input logic [31:0] r);
    ev_t e;
    int  n;
    checks++;
    n = (id == 0) ? q_a.size() : q_b.size();
    if (n == 0) begin
      errors++;
      $display("FAIL sb%0d unexpected %s at cyc %0d L=%h R=%h", id, kind.name(), cyc, l, r);
      return;
    end
    if (id == 0) e = q_a.pop_front();
    else         e = q_b.pop_front();
    if (e.kind != kind || e.cyc != cyc || (kind == EV_WR && (e.left !== l || e.right !== r))) begin
      errors++;
      $display("FAIL sb%0d event: got %s cyc %0d L=%h R=%h, expected %s cyc %0d L=%h R=%h",
               id, kind.name(), cyc, l, r, e.kind.name(), e.cyc, e.left, e.right);
    end
  endtask

  // Monitors sample half a cycle after the active edge.
  always @(negedge clk) begin
    if (a_ack === 1'b1)  sb_pop(0, EV_ACK, 32'd0, 32'd0);
    if (a_done === 1'b1) sb_pop(0, EV_DONE, 32'd0, 32'd0);
    if (a_wr === 1'b1)   sb_pop(0, EV_WR, a_left, a_right);
  end

  always @(negedge clk) begin
    if (b_ack === 1'b1)  sb_pop(1, EV_ACK, 32'd0, 32'd0);
    if (b_done === 1'b1) sb_pop(1, EV_DONE, 32'd0, 32'd0);
    if (b_wr === 1'b1)   sb_pop(1, EV_WR, b_left, b_right);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Drives a one-cycle request; t is the cycle in which it is sampled.
  task automatic req(input int id, input int clip, input bit loop, output int t);
    if (id == 0) begin a_req = 1; a_clip = clip[1:0]; a_loop = loop; end
    else         begin b_req = 1; b_clip = clip[2:0]; b_loop = loop; end
    t = cyc;
    step();
    a_req = 0;
    b_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    repeat (3) step();
    rst = 0;

    check("reset busy", {31'd0, a_busy}, 32'd0);
    check("reset rom_addr", {14'd0, a_addr}, 32'd0);
    check("reset drop_count", {24'd0, a_drop}, 32'd0);
    check("reset left", a_left, 32'd0);
    check("reset write", {31'd0, a_wr}, 32'd0);
    step();

    // 1: clip 0 one-shot
    req(0, 0, 0, t);
    push(0, EV_ACK, t + 1, 0);
    for (int k = 0; k < 4; k++) push(0, EV_WR, t + 4 * (k + 1), k);
    push(0, EV_DONE, t + 17, 0);
    check("t1 busy at accept+1", {31'd0, a_busy}, 32'd1);
    check("t1 rom_addr at accept+1", {14'd0, a_addr}, 32'd0);
    goto(t + 16);
    check("t1 busy before end", {31'd0, a_busy}, 32'd1);
    goto(t + 17);
    check("t1 busy after end", {31'd0, a_busy}, 32'd0);
    check("t1 left after end", a_left, 32'd0);
    goto(t + 20);

    // 2: single-sample clip, then an invalid index on the five-clip instance
    req(0, 2, 0, t);
    push(0, EV_ACK, t + 1, 0);
    push(0, EV_WR, t + 4, 10);
    push(0, EV_DONE, t + 5, 0);
    goto(t + 5);
    check("t2 busy after single", {31'd0, a_busy}, 32'd0);
    goto(t + 8);
    req(1, 5, 0, t);
    check("t2 invalid busy", {31'd0, b_busy}, 32'd0);
    goto(t + 4);
    check("t2 invalid rom_addr", {14'd0, b_addr}, 32'd0);

    // 3: clip 1 loop, stop on the 9th tick
    req(0, 1, 1, t);
    push(0, EV_ACK, t + 1, 0);
    for (int k = 0; k < 8; k++) push(0, EV_WR, t + 4 * (k + 1), 4 + (k % 6));
    goto(t + 36);
    a_stop = 1;
    step();
    a_stop = 0;
    check("t3 busy after stop", {31'd0, a_busy}, 32'd0);
    goto(t + 44);

    // 4a: pre-emption on the pre-emptive instance
    req(0, 3, 0, t);
    push(0, EV_ACK, t + 1, 0);
    push(0, EV_WR, t + 4, 11);
    push(0, EV_WR, t + 8, 12);
    goto(t + 9);
    req(0, 0, 0, t2);
    push(0, EV_ACK, t2 + 1, 0);
    for (int k = 0; k < 4; k++) push(0, EV_WR, t2 + 4 * (k + 1), k);
    push(0, EV_DONE, t2 + 17, 0);
    goto(t2 + 20);

    // 4b: request while busy is refused without pre-emption
    req(1, 3, 0, t);
    push(1, EV_ACK, t + 1, 0);
    for (int k = 0; k < 10; k++) push(1, EV_WR, t + 4 * (k + 1), 11 + k);
    push(1, EV_DONE, t + 41, 0);
    goto(t + 9);
    req(1, 0, 0, t2);
    check("t4b busy after refused req", {31'd0, b_busy}, 32'd1);
    goto(t + 41);
    check("t4b busy after end", {31'd0, b_busy}, 32'd0);
    goto(t + 44);

    // 5: three dropped ticks, addresses keep advancing
    a_allowed = 0;
    req(0, 1, 0, t);
    push(0, EV_ACK, t + 1, 0);
    push(0, EV_WR, t + 16, 7);
    push(0, EV_WR, t + 20, 8);
    push(0, EV_WR, t + 24, 9);
    push(0, EV_DONE, t + 25, 0);
    goto(t + 13);
    a_allowed = 1;
    check("t5 drop_count", {24'd0, a_drop}, 32'd3);
    goto(t + 28);
    check("t5 drop_count after clip", {24'd0, a_drop}, 32'd3);

    // drop_count saturation on the second instance
    b_allowed = 0;
    req(1, 1, 1, t);
    push(1, EV_ACK, t + 1, 0);
    goto(t + 1042);
    check("drop_count saturates", {24'd0, b_drop}, 32'd255);
    b_stop = 1;
    step();
    b_stop = 0;
    b_allowed = 1;
    check("sat busy after stop", {31'd0, b_busy}, 32'd0);
    goto(t + 1046);

    // 6: reset mid-clip, then request+stop together in idle
    req(0, 3, 0, t);
    push(0, EV_ACK, t + 1, 0);
    push(0, EV_WR, t + 4, 11);
    goto(t + 6);
    rst = 1;
    step();
    check("t6 reset busy", {31'd0, a_busy}, 32'd0);
    check("t6 reset rom_addr", {14'd0, a_addr}, 32'd0);
    check("t6 reset drop_count", {24'd0, a_drop}, 32'd0);
    check("t6 reset left", a_left, 32'd0);
    check("t6 reset right", a_right, 32'd0);
    check("t6 reset write", {31'd0, a_wr}, 32'd0);
    check("t6 reset done", {31'd0, a_done}, 32'd0);
    rst = 0;
    goto(t + 30);
    a_stop = 1;
    req(0, 1, 0, t);
    a_stop = 0;
    check("t6 stop+req busy", {31'd0, a_busy}, 32'd0);
    goto(t + 4);
    check("t6 stop+req busy later", {31'd0, a_busy}, 32'd0);
    step();

    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL sb0 leftover: %0d expected events never seen, first %s at cyc %0d",
               q_a.size(), q_a[0].kind.name(), q_a[0].cyc);
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL sb1 leftover: %0d expected events never seen, first %s at cyc %0d",
               q_b.size(), q_b[0].kind.name(), q_b[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
